adc_axis_framer: RTL and testbench



---
 rtl/adc_axis_pkg.sv | 21 ++
 rtl/adc_axis_framer_fifo.sv | 66 ++++++
 rtl/adc_axis_framer.sv | 220 ++++++++++++++++++++++
 tb/tb_adc_axis_framer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc_axis_pkg.sv
// Shared types and width helpers for the ADC-to-AXI4-Stream framer.
package adc_axis_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StDone    = 2'd2
    } state_e;

    function automatic int unsigned tdata_width(input int unsigned num_ch,
                                                input int unsigned sample_width,
                                                input int unsigned samples_per_beat);
        return num_ch * sample_width * samples_per_beat;
    endfunction

    // Occupancy counter must be able to represent a completely full FIFO.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/adc_axis_framer_fifo.sv
// First-word fall-through FIFO for {tuser, tlast, tdata} beats with occupancy count.
module adc_axis_framer_fifo
    import adc_axis_pkg::*;
#(
    parameter int unsigned Width = 66,
    parameter int unsigned Depth = 16,
    localparam int unsigned CntW = count_width(Depth)
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             wr_valid,
    input  logic [Width-1:0] wr_data,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [Width-1:0] rd_data,
    output logic [CntW-1:0]  count
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             wr_en;
    logic             rd_en;

    always_comb begin
        wr_en    = wr_valid && (count_q != CntW'(Depth));
        rd_en    = rd_ready && (count_q != '0);
        wr_ptr_d = wr_en ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Output forced to zero when empty so tdata/tlast/tuser read 0 with tvalid low.
    always_comb begin
        rd_valid = (count_q != '0);
        rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
        count    = count_q;
    end

endmodule

// File: rtl/adc_axis_framer.sv
// Packs parallel ADC samples into AXI4-Stream beats, cuts frames of programmable length and
// drops beats on overflow without ever leaving a frame unterminated in the stream.
module adc_axis_framer
    import adc_axis_pkg::*;
#(
    parameter int unsigned NUM_CH           = 2,
    parameter int unsigned SAMPLE_WIDTH     = 16,
    parameter int unsigned SAMPLES_PER_BEAT = 2,
    parameter int unsigned FIFO_DEPTH       = 16,
    parameter int unsigned FRAME_LEN_WIDTH  = 16,
    localparam int unsigned TDATA_WIDTH = tdata_width(NUM_CH, SAMPLE_WIDTH, SAMPLES_PER_BEAT)
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [NUM_CH*SAMPLE_WIDTH-1:0] s_sample_data,
    input  logic                           s_sample_valid,
    input  logic                           capture_enable,
    input  logic                           single_shot,
    input  logic [FRAME_LEN_WIDTH-1:0]     frame_len,
    input  logic                           clear_status,
    output logic [TDATA_WIDTH-1:0]         m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic [TDATA_WIDTH/8-1:0]       m_axis_tkeep,
    output logic                           m_axis_tuser,
    output logic                           busy,
    output logic                           overflow,
    output logic [15:0]                    dropped_beats,
    output logic [31:0]                    frame_count
);

    localparam int unsigned LaneW = NUM_CH * SAMPLE_WIDTH;
    localparam int unsigned IdxW  = (SAMPLES_PER_BEAT > 1) ? $clog2(SAMPLES_PER_BEAT) : 1;
    localparam int unsigned CntW  = count_width(FIFO_DEPTH);
    localparam int unsigned FifoW = TDATA_WIDTH + 2;

    state_e                     state_q, state_d;
    logic                       cap_en_q;
    logic                       cap_rise;
    logic                       single_shot_q, single_shot_d;
    logic [FRAME_LEN_WIDTH-1:0] frame_len_q, frame_len_d;
    logic [FRAME_LEN_WIDTH-1:0] eff_len;
    logic [FRAME_LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [IdxW-1:0]            samp_idx_q, samp_idx_d;
    logic [TDATA_WIDTH-1:0]     acc_q, acc_d;

    // Staging register between packer and FIFO; the drop decision is made here.
    logic                       stg_valid_q, stg_valid_d;
    logic                       stg_last_q, stg_last_d;
    logic [TDATA_WIDTH-1:0]     stg_data_q, stg_data_d;

    logic                       err_q, err_d;
    logic                       overflow_q, overflow_d;
    logic [15:0]                dropped_q, dropped_d;
    logic [31:0]                frame_count_q, frame_count_d;

    logic                       can_write;
    logic                       fifo_wr;
    logic                       drop;
    logic [FifoW-1:0]           fifo_wdata;
    logic [FifoW-1:0]           fifo_rdata;
    logic [CntW-1:0]            fifo_count;

    always_comb begin
        cap_rise = capture_enable && !cap_en_q;
        eff_len  = (frame_len == '0) ? FRAME_LEN_WIDTH'(1) : frame_len;
    end

    always_comb begin
        state_d       = state_q;
        single_shot_d = single_shot_q;
        frame_len_d   = frame_len_q;
        beat_cnt_d    = beat_cnt_q;
        samp_idx_d    = samp_idx_q;
        acc_d         = acc_q;
        stg_valid_d   = 1'b0;
        stg_last_d    = 1'b0;
        stg_data_d    = stg_data_q;
        unique case (state_q)
            StIdle: begin
                if (cap_rise) begin
                    state_d       = StCapture;
                    single_shot_d = single_shot;
                    frame_len_d   = eff_len;
                    beat_cnt_d    = '0;
                    samp_idx_d    = '0;
                end
            end
            StCapture: begin
                if (s_sample_valid) begin
                    for (int k = 0; k < int'(SAMPLES_PER_BEAT); k++) begin
                        if (samp_idx_q == IdxW'(k)) begin
                            acc_d[k*LaneW +: LaneW] = s_sample_data;
                        end
                    end
                    if (samp_idx_q == IdxW'(SAMPLES_PER_BEAT - 1)) begin
                        samp_idx_d  = '0;
                        stg_valid_d = 1'b1;
                        stg_data_d  = acc_d;
                        stg_last_d  = (beat_cnt_q == frame_len_q - FRAME_LEN_WIDTH'(1));
                        if (stg_last_d) begin
                            beat_cnt_d = '0;
                            if (!capture_enable || single_shot_q) begin
                                state_d = StDone;
                            end else begin
                                frame_len_d = eff_len;
                            end
                        end else begin
                            beat_cnt_d = beat_cnt_q + FRAME_LEN_WIDTH'(1);
                        end
                    end else begin
                        samp_idx_d = samp_idx_q + IdxW'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // A last beat may take the final slot; non-last beats must leave it free.
    always_comb begin
        can_write  = stg_last_q ? (fifo_count != CntW'(FIFO_DEPTH))
                                : (fifo_count < CntW'(FIFO_DEPTH - 1));
        fifo_wr    = stg_valid_q && can_write;
        drop       = stg_valid_q && !can_write;
        fifo_wdata = {err_q & stg_last_q, stg_last_q, stg_data_q};

        err_d = err_q;
        if (stg_valid_q && stg_last_q) begin
            err_d = 1'b0;
        end else if (drop) begin
            err_d = 1'b1;
        end

        overflow_d = overflow_q;
        dropped_d  = dropped_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_status) begin
                dropped_d = 16'd1;
            end else if (dropped_q != 16'hFFFF) begin
                dropped_d = dropped_q + 16'd1;
            end
        end else if (clear_status) begin
            overflow_d = 1'b0;
            dropped_d  = '0;
        end

        frame_count_d = frame_count_q;
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            frame_count_d = frame_count_q + 32'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= StIdle;
            cap_en_q      <= 1'b0;
            single_shot_q <= 1'b0;
            frame_len_q   <= FRAME_LEN_WIDTH'(1);
            beat_cnt_q    <= '0;
            samp_idx_q    <= '0;
            acc_q         <= '0;
            stg_valid_q   <= 1'b0;
            stg_last_q    <= 1'b0;
            stg_data_q    <= '0;
            err_q         <= 1'b0;
            overflow_q    <= 1'b0;
            dropped_q     <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cap_en_q      <= capture_enable;
            single_shot_q <= single_shot_d;
            frame_len_q   <= frame_len_d;
            beat_cnt_q    <= beat_cnt_d;
            samp_idx_q    <= samp_idx_d;
            acc_q         <= acc_d;
            stg_valid_q   <= stg_valid_d;
            stg_last_q    <= stg_last_d;
            stg_data_q    <= stg_data_d;
            err_q         <= err_d;
            overflow_q    <= overflow_d;
            dropped_q     <= dropped_d;
            frame_count_q <= frame_count_d;
        end
    end

    adc_axis_framer_fifo #(
        .Width (FifoW),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .wr_valid (fifo_wr),
        .wr_data  (fifo_wdata),
        .rd_ready (m_axis_tready),
        .rd_valid (m_axis_tvalid),
        .rd_data  (fifo_rdata),
        .count    (fifo_count)
    );

    always_comb begin
        m_axis_tuser  = fifo_rdata[FifoW-1];
        m_axis_tlast  = fifo_rdata[FifoW-2];
        m_axis_tdata  = fifo_rdata[TDATA_WIDTH-1:0];
        m_axis_tkeep  = '1;
        busy          = (state_q != StIdle);
        overflow      = overflow_q;
        dropped_beats = dropped_q;
        frame_count   = frame_count_q;
    end

endmodule

// File: tb/tb_adc_axis_framer.sv
// Directed self-checking bench for adc_axis_framer with default parameters.
module tb_adc_axis_framer;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] s_sample_data;
    logic        s_sample_valid;
    logic        capture_enable;
    logic        single_shot;
    logic [15:0] frame_len;
    logic        clear_status;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tuser;
    logic        busy;
    logic        overflow;
    logic [15:0] dropped_beats;
    logic [31:0] frame_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Each entry: {tuser, tlast, tdata}.
    logic [65:0] got_q[$];

    always #5 aclk = ~aclk;

    adc_axis_framer dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_sample_data  (s_sample_data),
        .s_sample_valid (s_sample_valid),
        .capture_enable (capture_enable),
        .single_shot    (single_shot),
        .frame_len      (frame_len),
        .clear_status   (clear_status),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tuser   (m_axis_tuser),
        .busy           (busy),
        .overflow       (overflow),
        .dropped_beats  (dropped_beats),
        .frame_count    (frame_count)
    );

    always @(negedge aclk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            got_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
        end
    end

    // Sample i: channel 0 = i, channel 1 = 0x100 + i.
    function automatic logic [31:0] samp(input int i);
        return {16'(32'h100 + i), 16'(i)};
    endfunction

    function automatic logic [63:0] exp_beat(input int first);
        return {samp(first + 1), samp(first)};
    endfunction

    function automatic logic [65:0] entry(input int i);
        if (i < got_q.size()) return got_q[i];
        return 'x;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int base, input int n, input int drop_at);
        for (int i = 0; i < n; i++) begin
            s_sample_data  = samp(base + i);
            s_sample_valid = 1'b1;
            if (i == drop_at) capture_enable = 1'b0;
            tick();
        end
        s_sample_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input string tag);
        int t = 0;
        while (got_q.size() < n && t < 300) begin
            tick();
            t++;
        end
        repeat (6) tick();
        check(tag, 66'(got_q.size()), 66'(n));
    endtask

    task automatic start_capture(input logic [15:0] len, input logic ss);
        got_q.delete();
        frame_len      = len;
        single_shot    = ss;
        capture_enable = 1'b1;
        tick();
    endtask

    initial begin
        aresetn        = 1'b0;
        s_sample_data  = '0;
        s_sample_valid = 1'b0;
        capture_enable = 1'b0;
        single_shot    = 1'b0;
        frame_len      = 16'd4;
        clear_status   = 1'b0;
        m_axis_tready  = 1'b1;
        repeat (3) tick();

        check("rst_tvalid", 66'(m_axis_tvalid), 66'(0));
        check("rst_tlast", 66'(m_axis_tlast), 66'(0));
        check("rst_tuser", 66'(m_axis_tuser), 66'(0));
        check("rst_busy", 66'(busy), 66'(0));
        check("rst_overflow", 66'(overflow), 66'(0));
        check("rst_dropped", 66'(dropped_beats), 66'(0));
        check("rst_frame_count", 66'(frame_count), 66'(0));
        check("rst_tdata", 66'(m_axis_tdata), 66'(0));
        check("rst_tkeep", 66'(m_axis_tkeep), 66'(8'hFF));
        aresetn = 1'b1;
        tick();

        // Continuous, two 4-beat frames; enable dropped inside the second frame.
        start_capture(16'd4, 1'b0);
        check("t1_busy", 66'(busy), 66'(1));
        send(0, 16, 14);
        wait_beats(8, "t1_beats");
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t1_data%0d", k), 66'(entry(k) & 66'hFFFF_FFFF_FFFF_FFFF),
                  66'(exp_beat(2 * k)));
            check($sformatf("t1_flags%0d", k), 66'(entry(k) >> 64), 66'((k % 4) == 3));
        end
        check("t1_frame_count", 66'(frame_count), 66'(2));
        check("t1_busy_end", 66'(busy), 66'(0));

        // Enable dropped after 5 beats: second frame still completes.
        start_capture(16'd4, 1'b0);
        send(50, 20, 10);
        wait_beats(8, "t3_beats");
        check("t3_last_data", 66'(entry(7) & 66'hFFFF_FFFF_FFFF_FFFF), 66'(exp_beat(64)));
        check("t3_last_flags", 66'(entry(7) >> 64), 66'(2'b01));
        check("t3_frame_count", 66'(frame_count), 66'(4));

        // Single shot, enable held high: one frame only.
        start_capture(16'd3, 1'b1);
        send(100, 12, -1);
        wait_beats(3, "t2_beats");
        check("t2_data0", 66'(entry(0) & 66'hFFFF_FFFF_FFFF_FFFF), 66'(exp_beat(100)));
        check("t2_flags2", 66'(entry(2) >> 64), 66'(2'b01));
        check("t2_busy", 66'(busy), 66'(0));
        check("t2_frame_count", 66'(frame_count), 66'(5));
        capture_enable = 1'b0;
        repeat (2) tick();
        start_capture(16'd3, 1'b1);
        send(130, 6, -1);
        wait_beats(3, "t2b_beats");
        check("t2b_data2", 66'(entry(2) & 66'hFFFF_FFFF_FFFF_FFFF), 66'(exp_beat(134)));
        check("t2b_frame_count", 66'(frame_count), 66'(6));
        capture_enable = 1'b0;
        repeat (2) tick();

        // frame_len = 0 behaves as 1: every beat is a last beat.
        start_capture(16'd0, 1'b0);
        send(160, 4, 3);
        wait_beats(2, "fl0_beats");
        check("fl0_flags0", 66'(entry(0) >> 64), 66'(2'b01));
        check("fl0_flags1", 66'(entry(1) >> 64), 66'(2'b01));
        check("fl0_frame_count", 66'(frame_count), 66'(8));

        // Backpressure: frame_len 5, 40 strobes. Frames A-C (15 beats) fill to 15, frame D
        // loses its 4 non-last beats and keeps its last beat in the final slot.
        m_axis_tready = 1'b0;
        start_capture(16'd5, 1'b0);
        send(200, 40, 34);
        repeat (4) tick();
        check("ovf_overflow", 66'(overflow), 66'(1));
        check("ovf_dropped", 66'(dropped_beats), 66'(4));
        check("ovf_tvalid", 66'(m_axis_tvalid), 66'(1));
        check("ovf_stall_data_a", 66'(m_axis_tdata), 66'(exp_beat(200)));
        repeat (3) tick();
        check("ovf_stall_data_b", 66'(m_axis_tdata), 66'(exp_beat(200)));
        m_axis_tready = 1'b1;
        wait_beats(16, "ovf_beats");
        check("ovf_flags4", 66'(entry(4) >> 64), 66'(2'b01));
        check("ovf_flags9", 66'(entry(9) >> 64), 66'(2'b01));
        check("ovf_flags14", 66'(entry(14) >> 64), 66'(2'b01));
        check("ovf_flags15", 66'(entry(15) >> 64), 66'(2'b11));
        check("ovf_data15", 66'(entry(15) & 66'hFFFF_FFFF_FFFF_FFFF), 66'(exp_beat(238)));
        check("ovf_frame_count", 66'(frame_count), 66'(12));

        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        check("clr_overflow", 66'(overflow), 66'(0));
        check("clr_dropped", 66'(dropped_beats), 66'(0));

        // Reset mid-frame with six beats queued and a partial beat pending.
        m_axis_tready = 1'b0;
        start_capture(16'd8, 1'b0);
        send(300, 13, -1);
        tick();
        check("mrst_pre_tvalid", 66'(m_axis_tvalid), 66'(1));
        aresetn        = 1'b0;
        capture_enable = 1'b0;
        #1;
        check("mrst_tvalid", 66'(m_axis_tvalid), 66'(0));
        check("mrst_busy", 66'(busy), 66'(0));
        check("mrst_frame_count", 66'(frame_count), 66'(0));
        check("mrst_tlast", 66'(m_axis_tlast), 66'(0));
        repeat (2) tick();
        aresetn       = 1'b1;
        m_axis_tready = 1'b1;
        tick();
        start_capture(16'd2, 1'b1);
        send(400, 4, -1);
        wait_beats(2, "mrst_beats");
        check("mrst_data0", 66'(entry(0) & 66'hFFFF_FFFF_FFFF_FFFF), 66'(exp_beat(400)));
        check("mrst_flags1", 66'(entry(1) >> 64), 66'(2'b01));
        check("mrst_frame_count_after", 66'(frame_count), 66'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
